ap_ctrl_driver: RTL and testbench

AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

---
 rtl/ap_ctrl_driver.sv | 151 +++++++++++++++
 tb/tb_ap_ctrl_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues ap_start runs (max 4 outstanding), times start-to-done latency; results 1 cycle after done.
// Backpressure via sink_ready -> ap_continue; optional watchdog under AP_CTRL_DRV_WATCHDOG_EN.
module ap_ctrl_driver (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cmd_start,
  input  logic [15:0] cmd_num_txn,
  output logic        cmd_busy,
  output logic        dut_ap_start,
  input  logic        dut_ap_ready,
  input  logic        dut_ap_done,
  output logic        dut_ap_continue,
  input  logic        sink_ready,
  input  logic [15:0] wd_limit,
  output logic        lat_valid,
  output logic [31:0] lat_cycles,
  output logic [31:0] ii_cycles,
  output logic [15:0] txn_idx,
  output logic        all_done,
  output logic        err_protocol,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] n_txn, issued, completed;
  logic [31:0] cycle_ctr, prev_ts;
  logic [31:0] fifo_ts [4];
  logic [31:0] fifo_ii [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        accept, start_hs, done_hs, pop, wd_expire, all_done_nxt;

  assign accept          = (state == IDLE) && cmd_start;
  assign cmd_busy        = (state != IDLE);
  // gated so the port reads 0 while reset is held
  assign dut_ap_continue = sink_ready & ap_rst_n;
  assign dut_ap_start    = (state == RUN) && !count[2] && !wd_expire;
  assign start_hs        = dut_ap_start & dut_ap_ready;
  assign done_hs         = dut_ap_done & dut_ap_continue;
  assign pop             = done_hs && (count != 3'd0);

`ifdef AP_CTRL_DRV_WATCHDOG_EN
  logic [15:0] wd_ctr;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wd_ctr <= 16'd0;
    end else if (!cmd_busy || start_hs || done_hs || wd_expire) begin
      wd_ctr <= 16'd0;
    end else begin
      wd_ctr <= wd_ctr + 16'd1;
    end
  end

  assign wd_expire = cmd_busy && (wd_limit != 16'd0) && (wd_ctr == wd_limit);
`else
  logic wd_limit_unused;
  assign wd_limit_unused = ^wd_limit;
  assign wd_expire       = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    all_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_num_txn != 16'd0) state_nxt = RUN;
          else                      all_done_nxt = 1'b1;
        end
      end
      RUN: begin
        if (start_hs && (issued + 16'd1 == n_txn)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && (completed + 16'd1 == n_txn)) begin
          state_nxt    = IDLE;
          all_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_expire) begin
      state_nxt    = IDLE;
      all_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      n_txn        <= 16'd0;
      issued       <= 16'd0;
      completed    <= 16'd0;
      cycle_ctr    <= 32'd0;
      prev_ts      <= 32'd0;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      lat_valid    <= 1'b0;
      lat_cycles   <= 32'd0;
      ii_cycles    <= 32'd0;
      txn_idx      <= 16'd0;
      all_done     <= 1'b0;
      err_protocol <= 1'b0;
      err_timeout  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_ts[i] <= 32'd0;
        fifo_ii[i] <= 32'd0;
      end
    end else begin
      state     <= state_nxt;
      all_done  <= all_done_nxt;
      cycle_ctr <= cycle_ctr + 32'd1;
      lat_valid <= pop;
      if (accept) begin
        n_txn        <= cmd_num_txn;
        issued       <= 16'd0;
        completed    <= 16'd0;
        err_protocol <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (start_hs) begin
        fifo_ts[wr_ptr] <= cycle_ctr;
        fifo_ii[wr_ptr] <= (issued == 16'd0) ? 32'd0 : cycle_ctr - prev_ts;
        prev_ts         <= cycle_ctr;
        wr_ptr          <= wr_ptr + 2'd1;
        issued          <= issued + 16'd1;
      end
      if (pop) begin
        lat_cycles <= cycle_ctr - fifo_ts[rd_ptr];
        ii_cycles  <= fifo_ii[rd_ptr];
        txn_idx    <= completed;
        completed  <= completed + 16'd1;
        rd_ptr     <= rd_ptr + 2'd1;
      end
      if (done_hs && (count == 3'd0)) err_protocol <= 1'b1;
      count <= count + {2'b00, start_hs} - {2'b00, pop};
      // a timed-out run leaves nothing outstanding behind
      if (wd_expire) begin
        err_timeout <= 1'b1;
        count       <= 3'd0;
        wr_ptr      <= 2'd0;
        rd_ptr      <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver: table of runs against a behavioural DUT model, plus corner sequences.
module tb_ap_ctrl_driver;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [15:0] cmd_num_txn = 16'd0;
  logic        cmd_busy, dut_ap_start, dut_ap_continue;
  logic        dut_ap_ready = 1'b0;
  logic        dut_ap_done = 1'b0;
  logic        sink_ready = 1'b1;
  logic [15:0] wd_limit = 16'd0;
  logic        lat_valid, all_done, err_protocol, err_timeout;
  logic [31:0] lat_cycles, ii_cycles;
  logic [15:0] txn_idx;

  ap_ctrl_driver dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_start(cmd_start), .cmd_num_txn(cmd_num_txn),
    .cmd_busy(cmd_busy), .dut_ap_start(dut_ap_start), .dut_ap_ready(dut_ap_ready),
    .dut_ap_done(dut_ap_done), .dut_ap_continue(dut_ap_continue), .sink_ready(sink_ready),
    .wd_limit(wd_limit), .lat_valid(lat_valid), .lat_cycles(lat_cycles), .ii_cycles(ii_cycles),
    .txn_idx(txn_idx), .all_done(all_done), .err_protocol(err_protocol), .err_timeout(err_timeout)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int              n;
    int              rmode;   // 0 never ready, 1 always ready, 2 ready the cycle after start rises
    int              delay;   // done raised this many edges after the start handshake
    int              stall;   // sink_ready held low for this many edges once done is up
    int              lat;
    logic [5:0][7:0] ii;      // expected ii per transaction, [0] = transaction 0
  } case_t;

  case_t tbl [4];
  int errors = 0;
  int checks = 0;

  // behavioural DUT / sink model
  int q [$];
  int cyc = 0;
  int rmode = 0, delay = 0, stall_left = 0;
  bit prev_start = 1'b0;
  int hs_total = 0, max_out = 0, viol = 0, cont_bad = 0;
  int pulses = 0, done_cnt = 0, cur_lat = 0;
  logic [5:0][7:0] cur_ii;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic r, d;
    @(negedge ap_clk);
    cyc++;
    if (lat_valid) begin
      chk($sformatf("lat_cycles[%0d]", pulses), lat_cycles, cur_lat);
      chk($sformatf("ii_cycles[%0d]", pulses), ii_cycles, (pulses < 6) ? {24'd0, cur_ii[pulses]} : 32'hFFFF_FFFF);
      chk($sformatf("txn_idx[%0d]", pulses), {16'd0, txn_idx}, pulses);
      pulses++;
    end
    if (all_done) done_cnt++;
    if (q.size() >= 4 && dut_ap_start) viol++;
    if (q.size() > max_out) max_out = q.size();
    case (rmode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      default: r = dut_ap_start && prev_start;
    endcase
    d = (q.size() > 0) && (q[0] <= cyc);
    dut_ap_ready = r;
    dut_ap_done  = d;
    if (d && stall_left > 0) begin
      sink_ready = 1'b0;
      stall_left--;
    end else begin
      sink_ready = 1'b1;
    end
    #1;
    if (d && !sink_ready && dut_ap_continue) cont_bad++;
    if (dut_ap_start && r) begin
      q.push_back(cyc + delay);
      hs_total++;
    end
    if (d && sink_ready) void'(q.pop_front());
    prev_start = dut_ap_start && !r;
  endtask

  task automatic begin_run(input int n);
    q.delete();
    pulses = 0; done_cnt = 0; viol = 0; max_out = 0; cont_bad = 0; hs_total = 0;
    step();
    cmd_num_txn = n[15:0];
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic run_case(input int i);
    rmode = tbl[i].rmode; delay = tbl[i].delay; stall_left = tbl[i].stall;
    cur_lat = tbl[i].lat; cur_ii = tbl[i].ii;
    begin_run(tbl[i].n);
    for (int k = 0; k < 300 && done_cnt == 0; k++) step();
    chk($sformatf("c%0d_all_done", i), done_cnt, 1);
    chk($sformatf("c%0d_pulses", i), pulses, tbl[i].n);
    chk($sformatf("c%0d_busy_after", i), {31'd0, cmd_busy}, 0);
    chk($sformatf("c%0d_continue_in_stall", i), cont_bad, 0);
    step();
    chk($sformatf("c%0d_all_done_one_cycle", i), done_cnt, 1);
  endtask

  initial begin
    tbl[0] = '{n: 1, rmode: 2, delay: 5,  stall: 0, lat: 5,  ii: 48'd0};
    tbl[1] = '{n: 6, rmode: 1, delay: 10, stall: 0, lat: 10, ii: {8'd1, 8'd8, 8'd1, 8'd1, 8'd1, 8'd0}};
    tbl[2] = '{n: 2, rmode: 1, delay: 3,  stall: 7, lat: 10, ii: {32'd0, 8'd1, 8'd0}};
    tbl[3] = '{n: 3, rmode: 1, delay: 2,  stall: 0, lat: 2,  ii: {24'd0, 8'd1, 8'd1, 8'd0}};

    // reset state, with sink_ready high to show continue is forced low
    #1;
    chk("rst_ctl", {25'd0, cmd_busy, dut_ap_start, dut_ap_continue, lat_valid, all_done, err_protocol, err_timeout}, 0);
    chk("rst_lat", lat_cycles, 0);
    chk("rst_ii", ii_cycles, 0);
    chk("rst_idx", {16'd0, txn_idx}, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // done with nothing outstanding
    step();
    dut_ap_done = 1'b1;
    step();
    chk("proto_err_set", {31'd0, err_protocol}, 1);
    chk("proto_no_lat", {31'd0, lat_valid}, 0);
    step();
    chk("proto_err_sticky", {31'd0, err_protocol}, 1);

    // null run
    cmd_num_txn = 16'd0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("null_all_done", {31'd0, all_done}, 1);
    chk("null_err_cleared", {31'd0, err_protocol}, 0);
    chk("null_not_busy", {31'd0, cmd_busy}, 0);
    chk("null_no_start", {31'd0, dut_ap_start}, 0);
    step();
    chk("null_all_done_drop", {31'd0, all_done}, 0);

    for (int i = 0; i < 4; i++) begin
      run_case(i);
      if (i == 1) begin
        chk("throttle_start_at_4", viol, 0);
        chk("throttle_max_out", max_out, 4);
      end
      if (i == 2) chk("stall_consumed", stall_left, 0);
    end

    // reset in the middle of a run
    rmode = 1; delay = 20; stall_left = 0;
    begin_run(4);
    for (int k = 0; k < 50 && hs_total < 2; k++) step();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {25'd0, cmd_busy, dut_ap_start, dut_ap_continue, lat_valid, all_done, err_protocol, err_timeout}, 0);
    chk("midrst_lat", lat_cycles, 0);
    chk("midrst_idx", {16'd0, txn_idx}, 0);
    dut_ap_ready = 1'b0;
    dut_ap_done = 1'b0;
    q.delete();
    step();
    step();
    ap_rst_n = 1'b1;
    chk("midrst_no_all_done", done_cnt, 0);
    run_case(0);

    // watchdog: DUT never ready
    wd_limit = 16'd20;
    rmode = 0; delay = 0; stall_left = 0;
    begin_run(1);
    repeat (9) step();
    chk("wd_early", {31'd0, err_timeout}, 0);
    repeat (20) step();
`ifdef AP_CTRL_DRV_WATCHDOG_EN
    chk("wd_err_timeout", {31'd0, err_timeout}, 1);
    chk("wd_start_low", {31'd0, dut_ap_start}, 0);
    chk("wd_not_busy", {31'd0, cmd_busy}, 0);
    chk("wd_no_all_done", done_cnt, 0);
`else
    chk("nowd_err_timeout", {31'd0, err_timeout}, 0);
    chk("nowd_still_busy", {31'd0, cmd_busy}, 1);
    chk("nowd_start_held", {31'd0, dut_ap_start}, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
